// File: rtl/regfile_rename.sv
// -----------------------------------------------------------------------------
// regfile_rename
//
// Architectural register file with per-register rename status for the
// out-of-order core. Each register holds a value, a busy bit and the ROB tag
// of the instruction that currently owns it. Issue reads source operands on two
// combinational read ports and claims (occupies) a destination register. ROB
// commit writes the retired value and releases ownership when the committing
// tag is still the owner. Flush drops every outstanding rename but keeps values.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When defined, a commit presented in the current cycle is forwarded onto
//   any read port addressing the same register. Occupy is never forwarded.
//   When undefined, reads reflect registered state only.
//
// Ports:
//   clk                    clock, all state updates on the rising edge
//   rst                    synchronous active-high reset, dominates all else
//   rd_addr1/2             source register indices
//   rd_value1/2            register value
//   rd_busy1/2             register is waiting for a ROB result
//   rd_tag1/2              owning ROB tag, 0 when not busy
//   occ_en/occ_reg/occ_tag issue claims occ_reg for ROB entry occ_tag
//   cm_en/cm_reg/cm_tag/cm_value
//                          ROB commit of cm_value to cm_reg by entry cm_tag
//   flush                  mispredict recovery, clears all busy bits and tags
//
// Interface protocol: there is no handshake. Every asserted enable (occ_en,
// cm_en, flush) is accepted in the cycle it is presented; reads are answered
// combinationally in the same cycle.
//
// Register 0 and any index >= REG_N read as value 0 / busy 0 / tag 0 and
// ignore occupy and commit. This falls out of the per-register decode below:
// only indices 1..REG_N-1 are ever matched.
// -----------------------------------------------------------------------------
module regfile_rename #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32,
    parameter int REG_W  = 5,
    parameter int ROB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [REG_W-1:0]  rd_addr1,
    input  logic [REG_W-1:0]  rd_addr2,
    output logic [DATA_W-1:0] rd_value1,
    output logic [DATA_W-1:0] rd_value2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic [ROB_W-1:0]  rd_tag1,
    output logic [ROB_W-1:0]  rd_tag2,

    input  logic              occ_en,
    input  logic [REG_W-1:0]  occ_reg,
    input  logic [ROB_W-1:0]  occ_tag,

    input  logic              cm_en,
    input  logic [REG_W-1:0]  cm_reg,
    input  logic [ROB_W-1:0]  cm_tag,
    input  logic [DATA_W-1:0] cm_value,

    input  logic              flush
);

    // -------------------------------------------------------------------------
    // Register state. Entry 0 exists only to keep indexing simple; it is held
    // at zero and never read.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] value_q [REG_N];
    logic [DATA_W-1:0] value_d [REG_N];
    logic              busy_q  [REG_N];
    logic              busy_d  [REG_N];
    logic [ROB_W-1:0]  tag_q   [REG_N];
    logic [ROB_W-1:0]  tag_d   [REG_N];

    // -------------------------------------------------------------------------
    // Next-state logic.
    // Order of precedence for rename state within one register:
    //   commit release  <  flush clear  <  occupy claim
    // Occupy is already gated by !flush, so a flushed cycle never claims.
    // The value path only listens to commit; flush never touches values.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < REG_N; i++) begin
            value_d[i] = value_q[i];
            busy_d[i]  = busy_q[i];
            tag_d[i]   = tag_q[i];
        end

        value_d[0] = '0;
        busy_d[0]  = 1'b0;
        tag_d[0]   = '0;

        for (int i = 1; i < REG_N; i++) begin
            if (cm_en && (cm_reg == REG_W'(i))) begin
                value_d[i] = cm_value;
                // Only the owning instruction releases the register; a stale
                // commit from an older owner leaves the younger claim intact.
                if (busy_q[i] && (tag_q[i] == cm_tag)) begin
                    busy_d[i] = 1'b0;
                    tag_d[i]  = '0;
                end
            end

            if (flush) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end

            if (occ_en && !flush && (occ_reg == REG_W'(i))) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = occ_tag;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers with synchronous reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                value_q[i] <= '0;
                busy_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports. Both ports share one body, indexed by port number.
    // -------------------------------------------------------------------------
    logic [REG_W-1:0]  rd_addr  [2];
    logic [DATA_W-1:0] rd_value [2];
    logic              rd_busy  [2];
    logic [ROB_W-1:0]  rd_tag   [2];
    logic              rd_hit   [2];

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_value[p] = '0;
            rd_busy[p]  = 1'b0;
            rd_tag[p]   = '0;
            rd_hit[p]   = 1'b0;

            // Register 0 and out-of-range indices never match, so they
            // fall through with the zero defaults above.
            for (int i = 1; i < REG_N; i++) begin
                if (rd_addr[p] == REG_W'(i)) begin
                    rd_value[p] = value_q[i];
                    rd_busy[p]  = busy_q[i];
                    rd_tag[p]   = tag_q[i];
                    rd_hit[p]   = 1'b1;
                end
            end

`ifdef REGFILE_BYPASS_EN
            // Same-cycle commit forwarding. The release decision mirrors the
            // registered path: the value always forwards, ownership is only
            // dropped when the committing tag matches the stored owner, and a
            // flush in the same cycle drops it regardless.
            if (rd_hit[p] && cm_en && (cm_reg == rd_addr[p])) begin
                rd_value[p] = cm_value;
                if (rd_tag[p] == cm_tag) begin
                    rd_busy[p] = 1'b0;
                    rd_tag[p]  = '0;
                end
                if (flush) begin
                    rd_busy[p] = 1'b0;
                    rd_tag[p]  = '0;
                end
            end
`endif
        end
    end

    assign rd_value1 = rd_value[0];
    assign rd_busy1  = rd_busy[0];
    assign rd_tag1   = rd_tag[0];
    assign rd_value2 = rd_value[1];
    assign rd_busy2  = rd_busy[1];
    assign rd_tag2   = rd_tag[1];

`ifndef REGFILE_BYPASS_EN
    // The hit flag only feeds the forwarding path; keep it referenced so the
    // plain build stays warning-free.
    logic rd_hit_unused;
    assign rd_hit_unused = rd_hit[0] | rd_hit[1];
`endif

endmodule

// File: tb/tb_regfile_rename.sv
// -----------------------------------------------------------------------------
// tb_regfile_rename
//
// Directed bench for regfile_rename. Driver tasks apply one cycle of stimulus
// at a time (inputs change 1 time unit after the rising edge). A check request
// drives the read addresses and pushes the hand-computed expected read result
// for both ports onto exp_q; a monitor on the falling edge pops and compares.
// Expected values that depend on commit forwarding follow REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_regfile_rename;

    localparam int DATA_W = 32;
    localparam int REG_N  = 32;
    localparam int REG_W  = 5;
    localparam int ROB_W  = 4;
    localparam int PORT_W = DATA_W + 1 + ROB_W;
    localparam int W      = 2 * PORT_W;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [REG_W-1:0]  rd_addr1, rd_addr2;
    logic [DATA_W-1:0] rd_value1, rd_value2;
    logic              rd_busy1, rd_busy2;
    logic [ROB_W-1:0]  rd_tag1, rd_tag2;
    logic              occ_en;
    logic [REG_W-1:0]  occ_reg;
    logic [ROB_W-1:0]  occ_tag;
    logic              cm_en;
    logic [REG_W-1:0]  cm_reg;
    logic [ROB_W-1:0]  cm_tag;
    logic [DATA_W-1:0] cm_value;
    logic              flush;

    regfile_rename #(
        .DATA_W(DATA_W), .REG_N(REG_N), .REG_W(REG_W), .ROB_W(ROB_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_value1(rd_value1), .rd_value2(rd_value2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .rd_tag1(rd_tag1), .rd_tag2(rd_tag2),
        .occ_en(occ_en), .occ_reg(occ_reg), .occ_tag(occ_tag),
        .cm_en(cm_en), .cm_reg(cm_reg), .cm_tag(cm_tag), .cm_value(cm_value),
        .flush(flush)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         chk_valid;
    int           vectors;
    int           miscompares;

    initial begin
        vectors     = 0;
        miscompares = 0;
    end

    always @(negedge clk) begin
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL monitor: read strobe with empty expected queue");
            end else begin
                logic [W-1:0]      e;
                logic [PORT_W-1:0] act1, act2, exp1, exp2;
                string             nm;
                e    = exp_q.pop_front();
                nm   = name_q.pop_front();
                exp1 = e[W-1:PORT_W];
                exp2 = e[PORT_W-1:0];
                act1 = {rd_value1, rd_busy1, rd_tag1};
                act2 = {rd_value2, rd_busy2, rd_tag2};
                vectors++;
                if (act1 !== exp1) begin
                    miscompares++;
                    $display("FAIL %s port1 addr %0d: got value=%h busy=%b tag=%h, expected value=%h busy=%b tag=%h",
                             nm, rd_addr1, act1[PORT_W-1:ROB_W+1], act1[ROB_W], act1[ROB_W-1:0],
                             exp1[PORT_W-1:ROB_W+1], exp1[ROB_W], exp1[ROB_W-1:0]);
                end
                vectors++;
                if (act2 !== exp2) begin
                    miscompares++;
                    $display("FAIL %s port2 addr %0d: got value=%h busy=%b tag=%h, expected value=%h busy=%b tag=%h",
                             nm, rd_addr2, act2[PORT_W-1:ROB_W+1], act2[ROB_W], act2[ROB_W-1:0],
                             exp2[PORT_W-1:ROB_W+1], exp2[ROB_W], exp2[ROB_W-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        occ_en    = 1'b0;
        cm_en     = 1'b0;
        flush     = 1'b0;
        chk_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic occ(input logic [REG_W-1:0] r, input logic [ROB_W-1:0] t);
        occ_en  = 1'b1;
        occ_reg = r;
        occ_tag = t;
    endtask

    task automatic cm(input logic [REG_W-1:0] r, input logic [ROB_W-1:0] t,
                      input logic [DATA_W-1:0] v);
        cm_en    = 1'b1;
        cm_reg   = r;
        cm_tag   = t;
        cm_value = v;
    endtask

    task automatic check(input string nm,
                         input logic [REG_W-1:0] a1, input logic [DATA_W-1:0] v1,
                         input logic b1, input logic [ROB_W-1:0] t1,
                         input logic [REG_W-1:0] a2, input logic [DATA_W-1:0] v2,
                         input logic b2, input logic [ROB_W-1:0] t2);
        rd_addr1 = a1;
        rd_addr2 = a2;
        exp_q.push_back({v1, b1, t1, v2, b2, t2});
        name_q.push_back(nm);
        chk_valid = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed vectors ----------------
    initial begin
        idle();
        rst      = 1'b1;
        rd_addr1 = '0;
        rd_addr2 = '0;
        occ_reg  = '0;
        occ_tag  = '0;
        cm_reg   = '0;
        cm_tag   = '0;
        cm_value = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state across all 32 registers, two per cycle.
        for (int i = 0; i < 16; i++) begin
            check("reset", REG_W'(2 * i), '0, 1'b0, '0, REG_W'(2 * i + 1), '0, 1'b0, '0);
            tick();
        end

        // Register 0 ignores occupy.
        occ(5'd0, 4'd5);
        tick();
        check("r0 hardwired", 5'd0, '0, 1'b0, '0, 5'd31, '0, 1'b0, '0);
        tick();

        // Occupy then matching commit; occupy is invisible in its own cycle.
        occ(5'd3, 4'd7);
        check("occ same cycle", 5'd3, '0, 1'b0, '0, 5'd0, '0, 1'b0, '0);
        tick();
        cm(5'd3, 4'd7, 32'hDEADBEEF);
        check("r3 commit cycle", 5'd3, BYP ? 32'hDEADBEEF : 32'h0, !BYP, BYP ? 4'd0 : 4'd7,
              5'd0, '0, 1'b0, '0);
        tick();
        check("r3 after commit", 5'd3, 32'hDEADBEEF, 1'b0, '0, 5'd0, '0, 1'b0, '0);
        tick();

        // Stale commit does not release a younger owner.
        occ(5'd4, 4'd2);
        tick();
        occ(5'd4, 4'd9);
        check("r4 prior owner", 5'd4, '0, 1'b1, 4'd2, 5'd3, 32'hDEADBEEF, 1'b0, '0);
        tick();
        cm(5'd4, 4'd2, 32'h11);
        check("r4 stale cm cycle", 5'd4, BYP ? 32'h11 : 32'h0, 1'b1, 4'd9, 5'd0, '0, 1'b0, '0);
        tick();
        check("r4 stale cm after", 5'd4, 32'h11, 1'b1, 4'd9, 5'd0, '0, 1'b0, '0);
        tick();

        // Commit and occupy on one register in one cycle: occupy wins rename.
        occ(5'd6, 4'd3);
        tick();
        cm(5'd6, 4'd3, 32'h55);
        occ(5'd6, 4'd8);
        check("r6 cm+occ cycle", 5'd6, BYP ? 32'h55 : 32'h0, !BYP, BYP ? 4'd0 : 4'd3,
              5'd4, 32'h11, 1'b1, 4'd9);
        tick();
        check("r6 cm+occ after", 5'd6, 32'h55, 1'b1, 4'd8, 5'd0, '0, 1'b0, '0);
        tick();

        // Flush with a concurrent occupy (dropped) and commit (value kept).
        occ(5'd1, 4'd1);
        tick();
        occ(5'd2, 4'd2);
        tick();
        occ(5'd5, 4'd5);
        tick();
        flush = 1'b1;
        occ(5'd7, 4'd4);
        cm(5'd1, 4'd1, 32'hA);
        check("flush cycle", 5'd1, BYP ? 32'hA : 32'h0, !BYP, BYP ? 4'd0 : 4'd1,
              5'd7, '0, 1'b0, '0);
        tick();
        check("flush r1/r7", 5'd1, 32'hA, 1'b0, '0, 5'd7, '0, 1'b0, '0);
        tick();
        check("flush r2/r5", 5'd2, '0, 1'b0, '0, 5'd5, '0, 1'b0, '0);
        tick();
        check("flush r4/r6", 5'd4, 32'h11, 1'b0, '0, 5'd6, 32'h55, 1'b0, '0);
        tick();

        // Matching commit observed on the read port in its own cycle.
        occ(5'd9, 4'd6);
        tick();
        cm(5'd9, 4'd6, 32'h1234);
        check("r9 commit cycle", 5'd9, BYP ? 32'h1234 : 32'h0, !BYP, BYP ? 4'd0 : 4'd6,
              5'd9, BYP ? 32'h1234 : 32'h0, !BYP, BYP ? 4'd0 : 4'd6);
        tick();
        check("r9 after commit", 5'd9, 32'h1234, 1'b0, '0, 5'd1, 32'hA, 1'b0, '0);
        tick();

        // Mismatched commit with flush: flush still clears ownership.
        occ(5'd10, 4'd3);
        tick();
        cm(5'd10, 4'd5, 32'h77);
        flush = 1'b1;
        check("r10 cm+flush cycle", 5'd10, BYP ? 32'h77 : 32'h0, !BYP, BYP ? 4'd0 : 4'd3,
              5'd0, '0, 1'b0, '0);
        tick();
        check("r10 cm+flush after", 5'd10, 32'h77, 1'b0, '0, 5'd9, 32'h1234, 1'b0, '0);
        tick();

        // Reset dominates occupy and commit in the same cycle and clears values.
        rst = 1'b1;
        occ(5'd12, 4'd1);
        cm(5'd12, 4'd1, 32'hFF);
        tick();
        rst = 1'b0;
        check("post reset r12/r1", 5'd12, '0, 1'b0, '0, 5'd1, '0, 1'b0, '0);
        tick();
        check("post reset r3/r10", 5'd3, '0, 1'b0, '0, 5'd10, '0, 1'b0, '0);
        tick();

        // Drain: every pushed expectation must have been consumed.
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            tick();
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
